// File: rtl/serial_deframer.sv
// Serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Delivers the word with single-cycle valid/error pulses as the stop bit is sampled.
module serial_deframer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sreg, sreg_n;
  logic              par, par_n;
  logic [DATA_W-1:0] dout_n;
  logic              dv_n, pe_n, fe_n, busy_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      par        <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sreg       <= sreg_n;
      par        <= par_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    par_n   = par;
    dout_n  = dout;
    dv_n    = 1'b0;
    pe_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && !sin) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (en) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt == CW'(i)) sreg_n[i] = sin;
          end
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1)) state_n = PARITY;
        end
      end
      PARITY: begin
        if (en) begin
          par_n   = sin;
          state_n = STOP;
        end
      end
      STOP: begin
        if (en) begin
          state_n = IDLE;
          if (sin) begin
            dout_n = sreg;
            dv_n   = 1'b1;
            pe_n   = (^sreg) ^ par;
          end else begin
            fe_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: directed frames plus random frames
// checked against a frame-level expectation model.
module tb_serial_deframer;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          sin;
  logic          en;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_dout;

  serial_deframer #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic s);
    @(negedge clk);
    en  = e;
    sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bit();
    cyc(1'b1, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_dv", dout_valid, 1'b0);
    chk1("idle_fe", frame_err, 1'b0);
  endtask

  // One frame; gap = number of en=0 cycles before each strobe.
  task automatic send_frame(input logic [DW-1:0] d, input logic pb,
                            input logic st, input int gap);
    logic [DW+2:0] bits;
    bits = {st, pb, d, 1'b0};
    for (int i = 0; i < DW + 3; i++) begin
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, 1'($urandom));
        chk1("gap_dv", dout_valid, 1'b0);
        chk1("gap_fe", frame_err, 1'b0);
        chk1("gap_busy", busy, i > 0);
      end
      cyc(1'b1, bits[i]);
      if (i < DW + 2) begin
        chk1("mid_busy", busy, 1'b1);
        chk1("mid_dv", dout_valid, 1'b0);
        chk1("mid_pe", parity_err, 1'b0);
        chk1("mid_fe", frame_err, 1'b0);
      end else if (st) begin
        exp_dout = d;
        chk1("stop_dv", dout_valid, 1'b1);
        chkw("stop_dout", dout, exp_dout);
        chk1("stop_pe", parity_err, (^d) ^ pb);
        chk1("stop_fe", frame_err, 1'b0);
        chk1("stop_busy", busy, 1'b0);
      end else begin
        chk1("ferr_fe", frame_err, 1'b1);
        chk1("ferr_dv", dout_valid, 1'b0);
        chk1("ferr_pe", parity_err, 1'b0);
        chkw("ferr_dout", dout, exp_dout);
        chk1("ferr_busy", busy, 1'b0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          pb;
    logic          st;
    rst_n    = 1'b0;
    en       = 1'b0;
    sin      = 1'b1;
    exp_dout = '0;
    #3;
    chkw("rst_dout", dout, '0);
    chk1("rst_dv", dout_valid, 1'b0);
    chk1("rst_pe", parity_err, 1'b0);
    chk1("rst_fe", frame_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle_bit();
    // good frame
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle_bit();
    // parity error
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle_bit();
    // framing error after good frame
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    idle_bit();
    // strobe every 4th cycle
    send_frame(8'hA5, 1'b0, 1'b1, 3);
    idle_bit();

    // reset mid-frame
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom));
    chk1("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_dout = '0;
    chk1("arst_busy", busy, 1'b0);
    chkw("arst_dout", dout, '0);
    chk1("arst_dv", dout_valid, 1'b0);
    #1 rst_n = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle_bit();

    // back-to-back
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    idle_bit();

    // random frames
    for (int n = 0; n < 40; n++) begin
      d  = DW'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, st, $urandom_range(0, 3));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle_bit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: sin  input  1  serial bit stream from the upstream two-stage shift register (already synchronised).
REQ-005 SHALL have port: en  input  1  bit strobe; sin is sampled only on rising edges where en=1.
REQ-006 SHALL have port: dout  output  DATA_W  last successfully received data word.
REQ-007 SHALL have port: dout_valid  output  1  one-cycle pulse: dout holds a new word.
REQ-008 SHALL have port: parity_err  output  1  one-cycle pulse, coincident with dout_valid, when the received parity is wrong.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse when the stop bit samples 0.
REQ-010 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL use frame format: start bit (0), DATA_W data bits LSB first, even parity bit, stop bit (1).
REQ-012 SHALL implement FSM states IDLE, DATA, PARITY, STOP; all registered outputs.
REQ-013 SHALL, in IDLE: on en=1 and sin=0, go to DATA with bit counter cleared; en=1 with sin=1, or en=0, stays in IDLE.
REQ-014 SHALL, in DATA: on each en=1, shift sin into the shift register at bit position equal to the counter (LSB first) and increment the counter; after the DATA_W-th bit, go to PARITY.
REQ-015 SHALL, in PARITY: on en=1, capture sin as the parity bit and go to STOP.
REQ-016 SHALL compute parity_ok = (XOR of all DATA_W data bits XOR parity bit) == 0.
REQ-017 SHALL, in STOP with en=1 and sin=1: load dout from the shift register, pulse dout_valid, pulse parity_err if !parity_ok, and go to IDLE.
REQ-018 SHALL, in STOP with en=1 and sin=0: pulse frame_err, leave dout unchanged, pulse neither dout_valid nor parity_err, and go to IDLE.
REQ-019 SHALL assert the pulses of REQ-017/018 for exactly one clk cycle, starting at the edge that samples the stop bit; latency from stop-bit sample to dout_valid SHALL be 0 edges.
REQ-020 SHALL hold all state when en=0, in every state; arbitrary gaps between strobes SHALL be tolerated.
REQ-021 SHALL accept back-to-back frames: a start bit on the first en after the stop bit SHALL begin a new frame.
REQ-022 SHALL size the bit counter to ceil(log2(DATA_W+1)) bits, with no wrap within a frame.
REQ-023 SHALL drive busy high from the edge that accepts the start bit until the edge that samples the stop bit.

Reset
REQ-024 SHALL, while rst_n=0, force FSM=IDLE, counter=0, shift register=0, dout=0, and dout_valid=parity_err=frame_err=busy=0, independent of clk.
REQ-025 SHALL, on reset mid-frame, discard the partial frame with no pulses; the first en after release is treated as in IDLE.

Verification
REQ-026 SHALL verify good frame: en every cycle, sin=0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB-first, parity 0, stop) -> dout=0xA5, dout_valid one cycle, parity_err=0, frame_err=0.
REQ-027 SHALL verify parity error: same frame with parity bit 1 -> dout=0xA5, dout_valid=1 and parity_err=1 in the same single cycle.
REQ-028 SHALL verify framing error: good 0xA5 frame, then 0x3C frame with stop=0 -> frame_err one cycle, no dout_valid, dout stays 0xA5.
REQ-029 SHALL verify strobe gaps: 0xA5 frame with en high every 4th cycle -> identical result to REQ-026; busy high throughout the frame.
REQ-030 SHALL verify reset mid-frame: start plus 4 data bits, pulse rst_n low asynchronously between edges, then a full 0x3C frame -> exactly one dout_valid with dout=0x3C.
REQ-031 SHALL verify back-to-back frames: frames 0x01 then 0xFF with no idle bits -> two dout_valid pulses, dout=0x01 then 0xFF, no errors.
